// File: rtl/nor_gate_pkg.sv
// Shared definitions for the nor_gate leaf cell.
// Holds default sizes and the counter word type.
package nor_gate_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;

  typedef logic [DEFAULT_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/nor_gate_cell.sv
// nor_cell: single-bit combinational NOR.
// Ports: a, b operands; y = ~(a | b).
module nor_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a | b);

endmodule

// File: rtl/nor_gate.sv
// nor_gate: bitwise NOR with registered copy, all-ones flag, change counter.
// Ports: clk, rst (async high), A, B, Y (comb), y_q, y_all, chg_cnt.
module nor_gate
  import nor_gate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_all,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic changed;
  logic at_max;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    nor_cell u_cell (
      .a(A[i]),
      .b(B[i]),
      .y(Y[i])
    );
  end

  // Compare the settled output against what was captured last edge.
  assign changed = (Y != y_q);
  assign at_max  = &chg_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      y_all   <= 1'b0;
      chg_cnt <= '0;
    end else begin
      y_q   <= Y;
      y_all <= &Y;
      // Saturate rather than wrap.
      if (changed && !at_max)
        chg_cnt <= chg_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_nor_gate.sv
// Testbench for nor_gate: scoreboard with random and directed stimulus.
// Two instances: WIDTH=1/CNT_W=16 and WIDTH=4/CNT_W=3.
module tb_nor_gate;

  logic        clk;
  logic        rst;
  logic        a1, b1, y1, yq1, all1;
  logic [15:0] cnt1;
  logic [3:0]  a4, b4, y4, yq4;
  logic        all4;
  logic [2:0]  cnt4;

  int n_chk;
  int n_fail;

  typedef struct {
    logic       y1, yq1, all1;
    int         cnt1;
    logic [3:0] y4, yq4;
    logic       all4;
    int         cnt4;
  } exp_t;

  exp_t sb_q[$];

  // reference state
  logic       m_yq1, m_all1;
  int         m_cnt1;
  logic [3:0] m_yq4;
  logic       m_all4;
  int         m_cnt4;

  nor_gate u1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Y(y1),
    .y_q(yq1), .y_all(all1), .chg_cnt(cnt1)
  );

  nor_gate #(.WIDTH(4), .CNT_W(3)) u4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .Y(y4),
    .y_q(yq4), .y_all(all4), .chg_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] nor4(logic [3:0] a, logic [3:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++)
      r[i] = (a[i] == 1'b0 && b[i] == 1'b0);
    return r;
  endfunction

  task automatic model_reset();
    m_yq1 = 1'b0; m_all1 = 1'b0; m_cnt1 = 0;
    m_yq4 = 4'h0; m_all4 = 1'b0; m_cnt4 = 0;
  endtask

  // One rising edge with the given (settled) inputs.
  task automatic model_edge();
    logic       y;
    logic [3:0] yy;
    y  = (a1 == 1'b0 && b1 == 1'b0);
    yy = nor4(a4, b4);
    if (y != m_yq1 && m_cnt1 < 65535) m_cnt1++;
    if (yy != m_yq4 && m_cnt4 < 7) m_cnt4++;
    m_yq1 = y;  m_all1 = y;
    m_yq4 = yy; m_all4 = (yy == 4'hf);
  endtask

  // Wait an edge, advance the model, push expectations, apply new inputs.
  task automatic step(logic na1, logic nb1, logic [3:0] na4, logic [3:0] nb4);
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    a1 = na1; b1 = nb1; a4 = na4; b4 = nb4;
    e.y1 = (na1 == 1'b0 && nb1 == 1'b0);
    e.yq1 = m_yq1; e.all1 = m_all1; e.cnt1 = m_cnt1;
    e.y4 = nor4(na4, nb4);
    e.yq4 = m_yq4; e.all4 = m_all4; e.cnt4 = m_cnt4;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && sb_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Reset with inputs zero, released just after a rising edge.
  task automatic do_reset();
    a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compare DUT against expectations away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("sb_Y1", 32'(y1), 32'(e.y1));
      chk("sb_yq1", 32'(yq1), 32'(e.yq1));
      chk("sb_all1", 32'(all1), 32'(e.all1));
      chk("sb_cnt1", 32'(cnt1), 32'(e.cnt1));
      chk("sb_Y4", 32'(y4), 32'(e.y4));
      chk("sb_yq4", 32'(yq4), 32'(e.yq4));
      chk("sb_all4", 32'(all4), 32'(e.all4));
      chk("sb_cnt4", 32'(cnt4), 32'(e.cnt4));
    end
  end

  initial begin
    logic [3:0] ta;
    logic [3:0] tb;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    model_reset();

    // reset state
    @(posedge clk);
    #1;
    chk("rst_Y1", 32'(y1), 32'd1);
    chk("rst_yq1", 32'(yq1), 32'd0);
    chk("rst_all1", 32'(all1), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    chk("rst_Y4", 32'(y4), 32'hf);
    chk("rst_cnt4", 32'(cnt4), 32'd0);

    // truth table, no edge needed
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i >> 1);
      b1 = 1'(i);
      #1;
      chk("tt_Y1", 32'(y1), (i == 0) ? 32'd1 : 32'd0);
      #9;
    end

    // release reset, one edge with A=B=0
    do_reset();
    step(1'b0, 1'b0, 4'h0, 4'h0);

    // registered latency sequence
    step(1'b0, 1'b1, 4'h0, 4'h0);
    step(1'b1, 1'b0, 4'h0, 4'h0);
    step(1'b1, 1'b1, 4'h0, 4'h0);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    drain();

    // random traffic
    for (int i = 0; i < 60; i++)
      step(1'($urandom), 1'($urandom),
           4'($urandom), 4'($urandom));
    drain();

    // async reset mid-run with cnt1 == 3
    do_reset();
    step(1'b1, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    drain();
    chk("pre_arst_cnt1", 32'(cnt1), 32'd3);
    rst = 1'b1;
    #1;
    chk("arst_yq1", 32'(yq1), 32'd0);
    chk("arst_all1", 32'(all1), 32'd0);
    chk("arst_cnt1", 32'(cnt1), 32'd0);
    chk("arst_cnt4", 32'(cnt4), 32'd0);
    a1 = 1'b1;
    #1;
    chk("arst_Y1_track", 32'(y1), 32'd0);
    a1 = 1'b0;
    #1;
    chk("arst_Y1_track2", 32'(y1), 32'd1);

    // saturation on the 3-bit counter
    do_reset();
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 4'((i + 1) & 1), 4'h0);
    drain();
    chk("sat_cnt4", 32'(cnt4), 32'd7);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 4'h1, 4'h0);
    drain();
    chk("sat_hold_cnt4", 32'(cnt4), 32'd7);

    // multi-bit operands
    ta = 4'b0101;
    tb = 4'b0011;
    a4 = ta;
    b4 = tb;
    #1;
    chk("mb_Y4", 32'(y4), 32'b1000);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    drain();
    chk("mb_all4", 32'(all4), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
